vga_framebuffer: RTL
====================

# vga_framebuffer

Pixel source directly upstream of the `vga` timing generator. It accepts the next-pixel coordinate (`pix_x`, `pix_y`), maps it to a down-scaled 12-bit RGB framebuffer, and returns the stored colour one cycle later on `color`. A valid/ready write port lets the CPU side draw pixels. A clear engine fills the whole buffer with one colour on reset and on request.

## Interface
- `FB_W`, 160: framebuffer width in stored pixels.
- `FB_H`, 120: framebuffer height in stored pixels.
- `SCALE_SHIFT`, 2: screen-to-buffer scale is 2^SCALE_SHIFT in both axes (640x480 maps to 160x120).
- `CLEAR_COLOR`, 12'h000: fill colour used after reset.

Ports:
- `clk` in 1: pixel clock, same as the `vga` block.
- `rst` in 1: asynchronous, active-high reset. It clears all state, not RAM contents.
- `pix_x` in 16: next screen x from `vga`.
- `pix_y` in 16: next screen y from `vga`.
- `color` out 12: {R[11:8], G[7:4], B[3:0]} for the requested pixel.
- `wr_valid` in 1: write request.
- `wr_ready` out 1: write accepted when high together with `wr_valid`.
- `wr_x` in 16: buffer x (unscaled).
- `wr_y` in 16: buffer y (unscaled).
- `wr_color` in 12: pixel value.
- `clr_start` in 1: one-cycle pulse; fill the buffer with `clr_color`.
- `clr_color` in 12: fill value, sampled on the `clr_start` cycle.
- `clr_busy` out 1: high while a fill is running.

## Operation
- Storage is FB_W*FB_H words of 12 bits. Address = y*FB_W + x, with ADDR_W = $clog2(FB_W*FB_H).
- The read path is dedicated, so the display is never stalled by writes.
  - fx = pix_x >> SCALE_SHIFT, fy = pix_y >> SCALE_SHIFT.
  - If fx >= FB_W or fy >= FB_H, `color` is 0 on the next cycle and the RAM output is ignored.
- The write path is shared by the CPU port and the clear engine. FSM states:
  - **CLEAR**: `wr_ready`=0, `clr_busy`=1. Writes the latched fill colour at address `clr_addr` and increments it every cycle. On the cycle writing address FB_W*FB_H-1, the FSM returns to IDLE.
  - **IDLE**: `wr_ready`=1, `clr_busy`=0.
    - A handshake (`wr_valid` & `wr_ready`) writes `wr_color` at (`wr_x`, `wr_y`).
    - If `wr_x` >= FB_W or `wr_y` >= FB_H, the write is accepted and dropped.
    - `clr_start` moves the FSM to CLEAR with `clr_addr`=0.
- After reset the FSM is in CLEAR with the fill colour = CLEAR_COLOR, so the buffer always starts defined.
- Simultaneous `clr_start` and write handshake in IDLE: the write is performed that cycle, then the clear begins. The clear overwrites it.
- `clr_start` during CLEAR is ignored; the running fill is not restarted.
- Read and write to the same address in the same cycle: `color` returns the old data (read-first).
- All multiplies are against constant FB_W and are computed at ADDR_W bits. Coordinates are range-checked before the multiply, so nothing can overflow.

## Timing
- Read latency is exactly 1 cycle: the `pix_x`/`pix_y` presented at edge N produce `color` valid after edge N+1.
  - This matches `vga` presenting coordinate+1 one cycle ahead.
- Writes land in RAM at the accepting edge and are visible to a read issued the following cycle.
- A clear takes FB_W*FB_H cycles: 19200 with defaults.
  - `clr_busy` rises the cycle after `clr_start`.
  - `clr_busy` falls the cycle after the last address is written.
- Reset values: `color`=0, `wr_ready`=0, `clr_busy`=1, FSM=CLEAR, `clr_addr`=0.
- Reset asserted mid-clear or mid-write: state returns immediately to the reset values and the fill restarts from address 0 with CLEAR_COLOR after release.

## Structure
- Shared package `vga_pkg`:
  - `color_t` (logic [11:0]).
  - FSM enum `fb_state_t` {FB_IDLE, FB_CLEAR}.
  - 640x480 timing constants shared with `vga`.
- Sub-module `fb_ram`: simple dual-port synchronous RAM with one write port and one registered read-first read port. Parameters DEPTH and WIDTH=12. No reset, so it infers block RAM.
- Top level: read address/range pipeline, write mux, clear FSM and counter.

## Test plan
- Reset release -> `clr_busy`=1 for 19200 cycles. Afterwards, reads of (0,0), (639,479) and (320,240) all return 12'h000.
- IDLE, write (10,5,12'hF0A) -> `wr_ready`=1 and accepted. Screen coordinates (40..43, 20..23) then return 12'hF0A one cycle after presentation; (44,20) returns 0.
- Write (160,0) and (0,120) -> both accepted, no RAM change. Screen (639,479) reads the old value; screen (700,10) reads 0.
- `clr_start` with `clr_color`=12'h123 at the same time as a write to (1,1) -> the write is accepted, `clr_busy` rises next cycle, and `wr_valid` is held off (`wr_ready`=0) for 19200 cycles. Afterwards (1,1) reads 12'h123.
- Continuous `vga`-style raster of 640x480 with a diagonal pattern written -> every `color` matches the model delayed by 1 cycle; blanking coordinates (0,0) return the buffer value at (0,0).
- `rst` pulsed at clear address 5000 -> `clr_busy` stays 1, the fill restarts at address 0 with CLEAR_COLOR, and completes 19200 cycles after release.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA definitions: pixel colour type, framebuffer FSM states
// and 640x480 timing constants used by both vga and vga_framebuffer.
package vga_pkg;

  typedef logic [11:0] color_t;

  typedef enum logic {
    FB_IDLE,
    FB_CLEAR
  } fb_state_t;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

endpackage

// File: rtl/fb_ram.sv
// Simple dual-port RAM: one write port, one registered read-first
// read port. No reset so it maps onto block RAM.
module fb_ram #(
  parameter int DEPTH = 19200,
  parameter int WIDTH = 12,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/vga_framebuffer.sv
// Down-scaled 12-bit framebuffer feeding the vga timing block, with a
// CPU write port and a clear engine sharing the RAM write side.
module vga_framebuffer
  import vga_pkg::*;
#(
  parameter int     FB_W        = 160,
  parameter int     FB_H        = 120,
  parameter int     SCALE_SHIFT = 2,
  parameter color_t CLEAR_COLOR = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pix_x,
  input  logic [15:0] pix_y,
  output color_t      color,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [15:0] wr_x,
  input  logic [15:0] wr_y,
  input  color_t      wr_color,
  input  logic        clr_start,
  input  color_t      clr_color,
  output logic        clr_busy
);

  localparam int DEPTH  = FB_W * FB_H;
  localparam int ADDR_W = $clog2(DEPTH);

  localparam logic [15:0]       W16  = 16'(FB_W);
  localparam logic [15:0]       H16  = 16'(FB_H);
  localparam logic [ADDR_W-1:0] WMUL = ADDR_W'(FB_W);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [15:0]       fx;
  logic [15:0]       fy;
  logic              rd_ok;
  logic              rd_ok_q;
  logic [ADDR_W-1:0] rd_addr;
  color_t            ram_q;

  // Range check first so the multiply only sees in-range coordinates.
  assign fx      = pix_x >> SCALE_SHIFT;
  assign fy      = pix_y >> SCALE_SHIFT;
  assign rd_ok   = (fx < W16) && (fy < H16);
  assign rd_addr = rd_ok ? ADDR_W'(fy) * WMUL + ADDR_W'(fx) : '0;

  logic              wr_ok;
  logic [ADDR_W-1:0] wr_addr;

  assign wr_ok   = (wr_x < W16) && (wr_y < H16);
  assign wr_addr = wr_ok ? ADDR_W'(wr_y) * WMUL + ADDR_W'(wr_x) : '0;

  fb_state_t         state_q;
  fb_state_t         state_d;
  logic [ADDR_W-1:0] clr_addr_q;
  logic [ADDR_W-1:0] clr_addr_d;
  color_t            fill_q;
  color_t            fill_d;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  color_t            wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FB_CLEAR;
      clr_addr_q <= '0;
      fill_q     <= CLEAR_COLOR;
      rd_ok_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      fill_q     <= fill_d;
      rd_ok_q    <= rd_ok;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    fill_d     = fill_q;
    we         = 1'b0;
    waddr      = '0;
    wdata      = '0;
    wr_ready   = 1'b0;
    clr_busy   = 1'b0;
    unique case (state_q)
      FB_IDLE: begin
        wr_ready = 1'b1;
        if (wr_valid && wr_ok) begin
          we    = 1'b1;
          waddr = wr_addr;
          wdata = wr_color;
        end
        if (clr_start) begin
          state_d    = FB_CLEAR;
          clr_addr_d = '0;
          fill_d     = clr_color;
        end
      end
      FB_CLEAR: begin
        clr_busy   = 1'b1;
        we         = 1'b1;
        waddr      = clr_addr_q;
        wdata      = fill_q;
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == LAST) begin
          state_d    = FB_IDLE;
          clr_addr_d = '0;
        end
      end
    endcase
  end

  fb_ram #(
    .DEPTH(DEPTH),
    .WIDTH(12),
    .AW   (ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (we),
    .waddr(waddr),
    .wdata(wdata),
    .raddr(rd_addr),
    .rdata(ram_q)
  );

  assign color = rd_ok_q ? ram_q : 12'h000;

endmodule
